// File: rtl/booth_mac_acc.sv
// Operand-issue and product-accumulate stage around a combinational Booth multiplier.
// Pairs are registered onto the multiplier inputs, and products are summed into a guard-extended accumulator.
module booth_mac_acc #(
    parameter int LENGTH    = 32,
    parameter int ACC_GUARD = 8,
    parameter int CNT_W     = 8,
    parameter int SIGNED    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_vld,
    output logic                            in_rdy,
    input  logic [LENGTH-1:0]               in_a,
    input  logic [LENGTH-1:0]               in_b,
    input  logic                            in_last,
    output logic [LENGTH-1:0]               mul_a,
    output logic [LENGTH-1:0]               mul_b,
    input  logic [2*LENGTH-1:0]             mul_p,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output logic [2*LENGTH+ACC_GUARD-1:0]   out_acc,
    output logic [CNT_W-1:0]                out_cnt,
    output logic                            out_ovf
);

    localparam int PROD_W = 2 * LENGTH;
    localparam int ACC_W  = PROD_W + ACC_GUARD;
    localparam logic SIGN_EXT = (SIGNED != 0);

    logic               s1_vld;
    logic               s1_last;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic               s1_adv;
    logic               in_hs;
    logic               acc_en;
    logic               load_out;
    logic [ACC_W-1:0]   ext_p;
    logic [ACC_W-1:0]   sum;
    logic               carry;
    logic [CNT_W-1:0]   cnt_n;
    logic               cnt_sat;
    logic               add_ovf;
    logic               ovf_n;

    // Only a last pair that would overwrite an unconsumed result has to wait.
    assign s1_adv   = !(s1_vld && s1_last && out_vld && !out_rdy);
    assign in_rdy   = !s1_vld || s1_adv;
    assign in_hs    = in_vld && in_rdy;
    assign acc_en   = s1_vld && s1_adv;
    assign load_out = acc_en && s1_last;

    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch is inferred.
        ext_p   = {{ACC_GUARD{1'b0}}, mul_p};
        add_ovf = 1'b0;
        if (SIGN_EXT) begin
            ext_p = {{ACC_GUARD{mul_p[PROD_W-1]}}, mul_p};
        end
        {carry, sum} = {1'b0, acc} + {1'b0, ext_p};
        cnt_sat = &cnt;
        cnt_n   = cnt_sat ? cnt : cnt + CNT_W'(1);
        if (SIGN_EXT) begin
            add_ovf = (acc[ACC_W-1] == ext_p[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            add_ovf = carry;
        end
        ovf_n = ovf || add_ovf || cnt_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else if (s1_adv) begin
            // NOTE: non-blocking assignments keep register updates order-independent.
            s1_vld <= in_hs;
            if (in_hs) begin
                mul_a   <= in_a;
                mul_b   <= in_b;
                s1_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (acc_en) begin
            if (s1_last) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= sum;
                cnt <= cnt_n;
                ovf <= ovf_n;
            end
        end
    end

    // A new result loads in the same edge that the old one drains, so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_acc <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else if (load_out) begin
            out_vld <= 1'b1;
            out_acc <= sum;
            out_cnt <= cnt_n;
            out_ovf <= ovf_n;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Self-checking bench for booth_mac_acc: an arithmetic dot-product model and a scoreboard queue,
// directed vectors with literal expectations, and an unsigned-build instance.
module tb_booth_mac_acc;

    localparam int LENGTH = 32;
    localparam int ACC_W  = 72;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        int               cnt;
        bit               ovf;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;

    logic               in_vld = 1'b0;
    logic               in_rdy;
    logic [LENGTH-1:0]  in_a = '0;
    logic [LENGTH-1:0]  in_b = '0;
    logic               in_last = 1'b0;
    logic [LENGTH-1:0]  mul_a;
    logic [LENGTH-1:0]  mul_b;
    logic [63:0]        mul_p;
    logic               out_vld;
    logic               out_rdy = 1'b1;
    logic [ACC_W-1:0]   out_acc;
    logic [CNT_W-1:0]   out_cnt;
    logic               out_ovf;

    logic               u_in_vld = 1'b0;
    logic               u_in_rdy;
    logic [LENGTH-1:0]  u_in_a = '0;
    logic [LENGTH-1:0]  u_in_b = '0;
    logic               u_in_last = 1'b0;
    logic [LENGTH-1:0]  u_mul_a;
    logic [LENGTH-1:0]  u_mul_b;
    logic [63:0]        u_mul_p;
    logic               u_out_vld;
    logic               u_out_rdy = 1'b1;
    logic [ACC_W-1:0]   u_out_acc;
    logic [CNT_W-1:0]   u_out_cnt;
    logic               u_out_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    res_t             exp_q[$];
    logic [ACC_W-1:0] m_acc = '0;
    int               m_n   = 0;
    bit               m_ovf = 1'b0;

    always #5 clk = ~clk;

    // Multiplier stand-ins: plain signed and unsigned products.
    assign mul_p   = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    assign u_mul_p = {32'b0, u_mul_a} * {32'b0, u_mul_b};

    booth_mac_acc #(.LENGTH(LENGTH), .ACC_GUARD(8), .CNT_W(CNT_W), .SIGNED(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    booth_mac_acc #(.LENGTH(LENGTH), .ACC_GUARD(8), .CNT_W(CNT_W), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst),
        .in_vld(u_in_vld), .in_rdy(u_in_rdy), .in_a(u_in_a), .in_b(u_in_b), .in_last(u_in_last),
        .mul_a(u_mul_a), .mul_b(u_mul_b), .mul_p(u_mul_p),
        .out_vld(u_out_vld), .out_rdy(u_out_rdy), .out_acc(u_out_acc), .out_cnt(u_out_cnt), .out_ovf(u_out_ovf)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ACC_W-1:0] s72(input longint v);
        s72 = {{8{v[63]}}, v};
    endfunction

    // Dot-product model: exact wide sum, wrap into ACC_W, sticky overflow, saturating count.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input bit last);
        longint pa, pb;
        logic signed [127:0] ex;
        logic signed [ACC_W-1:0] acc_s;
        res_t r;
        pa = $signed(a);
        pb = $signed(b);
        acc_s = $signed(m_acc);
        ex = acc_s + (pa * pb);
        if (ex != $signed(ex[ACC_W-1:0])) m_ovf = 1'b1;
        m_acc = ex[ACC_W-1:0];
        m_n++;
        if (m_n > 255) m_ovf = 1'b1;
        if (last) begin
            r.acc = m_acc;
            r.cnt = (m_n > 255) ? 255 : m_n;
            r.ovf = m_ovf;
            exp_q.push_back(r);
            m_acc = '0;
            m_n   = 0;
            m_ovf = 1'b0;
        end
    endtask

    // Scoreboard: every cycle a result is presented it must match the head of the queue.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_acc = '0;
            m_n   = 0;
            m_ovf = 1'b0;
        end else begin
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    check("sb_acc", out_acc, exp_q[0].acc);
                    check("sb_cnt", out_cnt, exp_q[0].cnt);
                    check("sb_ovf", out_ovf, exp_q[0].ovf);
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end
            if (in_vld && in_rdy) model_accept(in_a, in_b, in_last);
        end
    end

    // Entered and left at posedge+1; each call completes one handshake.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last);
        bit got = 1'b0;
        in_vld = 1'b1; in_a = a; in_b = b; in_last = last;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = in_rdy;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic expect_out(input string name, input logic [ACC_W-1:0] acc, input int cnt, input bit ovf);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_vld;
        end
        check({name, "_vld"}, seen, 1);
        if (seen) begin
            check({name, "_acc"}, out_acc, acc);
            check({name, "_cnt"}, out_cnt, cnt);
            check({name, "_ovf"}, out_ovf, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [ACC_W-1:0] e;

        #3;
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        #9 rst = 1'b0;
        #1 check("rel_in_rdy", in_rdy, 1);
        @(posedge clk); #1;

        // Single pair: 3 * -5, latency two cycles from the handshake.
        send(32'd3, 32'hFFFF_FFFB, 1'b1);
        @(negedge clk);
        check("single_mul_a", mul_a, 32'd3);
        check("single_mul_b", mul_b, 32'hFFFF_FFFB);
        check("single_early_vld", out_vld, 0);
        @(negedge clk);
        check("single_vld", out_vld, 1);
        check("single_acc", out_acc, s72(-15));
        check("single_cnt", out_cnt, 1);
        check("single_ovf", out_ovf, 0);
        @(posedge clk); #1;

        // Dot product, then a fresh group to show the accumulator cleared.
        send(32'd1, 32'd2, 1'b0);
        send(32'd3, 32'd4, 1'b0);
        send(-32'sd5, 32'd6, 1'b0);
        send(32'd7, -32'sd8, 1'b1);
        expect_out("dot", s72(-72), 4, 1'b0);
        send(32'd2, 32'd2, 1'b1);
        expect_out("dot_next", s72(4), 1, 1'b0);

        // Extremes: 255 and 300 products of 2^62.
        for (int i = 0; i < 255; i++) send(32'h8000_0000, 32'h8000_0000, i == 254);
        e = 72'd255 << 62;
        expect_out("ext255", e, 255, 1'b0);
        for (int i = 0; i < 300; i++) send(32'h8000_0000, 32'h8000_0000, i == 299);
        e = 72'd300 << 62;
        expect_out("ext300", e, 255, 1'b1);

        // Backpressure: result 1 must hold and the following pair must wait.
        out_rdy = 1'b0;
        send(32'd1, 32'd1, 1'b1);
        send(32'd2, 32'd3, 1'b1);
        in_vld = 1'b1; in_a = 32'd5; in_b = 32'd5; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_rdy_low", in_rdy, 0);
            check("bp_hold_vld", out_vld, 1);
            check("bp_hold_acc", out_acc, 1);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_first_acc", out_acc, 1);
        check("bp_in_rdy_high", in_rdy, 1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(negedge clk);
        check("bp_second_vld", out_vld, 1);
        check("bp_second_acc", out_acc, 6);
        expect_out("bp_third", s72(25), 1, 1'b0);

        // Asynchronous reset in the middle of a group.
        send(32'd10, 32'd10, 1'b0);
        send(32'd10, 32'd10, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_vld", out_vld, 0);
        check("mid_rst_out_acc", out_acc, 0);
        check("mid_rst_out_cnt", out_cnt, 0);
        check("mid_rst_out_ovf", out_ovf, 0);
        check("mid_rst_mul_a", mul_a, 0);
        check("mid_rst_mul_b", mul_b, 0);
        check("mid_rst_in_rdy", in_rdy, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        send(32'd4, 32'd4, 1'b1);
        expect_out("post_rst", s72(16), 1, 1'b0);

        // Unsigned build: 0xFFFFFFFF squared, zero-extended.
        u_in_vld = 1'b1; u_in_a = 32'hFFFF_FFFF; u_in_b = 32'hFFFF_FFFF; u_in_last = 1'b1;
        @(negedge clk);
        check("uns_in_rdy", u_in_rdy, 1);
        @(posedge clk); #1;
        u_in_vld = 1'b0;
        @(negedge clk);
        check("uns_early_vld", u_out_vld, 0);
        @(negedge clk);
        check("uns_vld", u_out_vld, 1);
        check("uns_acc", u_out_acc, 72'h00_FFFF_FFFE_0000_0001);
        check("uns_cnt", u_out_cnt, 1);
        check("uns_ovf", u_out_ovf, 0);
        @(posedge clk); #1;

        repeat (4) @(posedge clk);
        #1;
        check("sb_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mac_acc.md
# booth_mac_acc

Operand-issue and product-accumulate stage wrapped around the combinational radix-16 Booth multiplier. It accepts operand pairs over a valid/ready handshake and registers them onto the multiplier's A/B inputs. One cycle later it captures the 64-bit product and accumulates it into a guard-extended accumulator. On the pair flagged `in_last`, it emits the dot-product result through a one-entry output register with backpressure.

## Interface
Parameters:
- `LENGTH`, 32: operand width; product width is 2*LENGTH.
- `ACC_GUARD`, 8: guard bits above the product width; accumulator width ACC_W = 2*LENGTH+ACC_GUARD.
- `CNT_W`, 8: width of the product counter.
- `SIGNED`, 1: 1 = product sign-extended into the accumulator; 0 = zero-extended. Must match the multiplier's signedness build option.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_vld` in 1: operand pair valid.
- `in_rdy` out 1: block can take a pair this cycle.
- `in_a` in LENGTH: operand A (multiplier).
- `in_b` in LENGTH: operand B (multiplicand).
- `in_last` in 1: this pair closes the current dot product.
- `mul_a` out LENGTH: registered A, drives multiplier A.
- `mul_b` out LENGTH: registered B, drives multiplier B.
- `mul_p` in 2*LENGTH: multiplier product, combinational from `mul_a`/`mul_b`.
- `out_vld` out 1: result valid.
- `out_rdy` in 1: consumer accepts result.
- `out_acc` out ACC_W: accumulated result.
- `out_cnt` out CNT_W: number of products in `out_acc`.
- `out_ovf` out 1: accumulator signed/unsigned overflow or count saturation occurred in this group.

## Operation
- **S1 (issue):** on input handshake (`in_vld && in_rdy`), load `mul_a`/`mul_b` from `in_a`/`in_b`, set `s1_vld`, and latch `s1_last`. Without a handshake, `s1_vld` clears; `mul_a`/`mul_b` hold.
- **S2 (accumulate):** when `s1_vld` and S1 advances, form `ext_p`, which is `mul_p` sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
  - `sum = acc + ext_p`; `cnt_n = cnt + 1`, saturating at 2^CNT_W-1.
  - `ovf_n = ovf` OR add overflow OR count saturation.
  - Add overflow means: for SIGNED=1, operand signs equal and sum sign differs; for SIGNED=0, carry out of ACC_W.
- **Non-last pair:** `acc <= sum`, `cnt <= cnt_n`, `ovf <= ovf_n`.
- **Last pair:**
  - `out_acc <= sum`, `out_cnt <= cnt_n`, `out_ovf <= ovf_n`, `out_vld <= 1`.
  - `acc`, `cnt`, `ovf` clear to 0, so the next pair starts a fresh group.
- **Stall:** S1 cannot advance when `s1_vld && s1_last && out_vld && !out_rdy`. While stalled, S1, `acc`, `cnt` and `ovf` all hold.
- **Ready:** `in_rdy = !s1_vld || s1_adv`. This is combinational from `out_rdy`; there is no combinational path from `in_vld` to `in_rdy`.
- **Output:** `out_vld` clears on `out_vld && out_rdy` unless a new last result loads on the same edge. Load takes priority; no bubble.
- **Output hold:** `out_acc`/`out_cnt`/`out_ovf` stay stable while `out_vld && !out_rdy`.
- **Reset:** asserting `rst` at any time discards the partial group and any pending output.
- **Reset values:** `in_rdy` 1 (it is combinational from `s1_vld`=0); `mul_a`, `mul_b`, `out_vld`, `out_acc`, `out_cnt`, `out_ovf` all 0; internal `acc`, `cnt`, `ovf`, `s1_vld`, `s1_last` all 0.

## Timing
- **Latency:** handshake in cycle k gives `mul_a`/`mul_b` valid in cycle k+1. If `in_last`, `out_vld` is high in cycle k+2.
- **Throughput:** one pair per cycle, sustained with no backpressure.
- **Critical path:** the full multiplier path from `mul_a`/`mul_b` to `mul_p`, plus the ACC_W adder, lies within one cycle. No additional pipelining.
- **Simultaneous events:** output drain and last-load in the same cycle are legal; the new result replaces the old one at the edge.
- **Back-to-back groups:** back-to-back single-pair groups (every pair last) give one result per cycle when `out_rdy`=1.
- **Stall behaviour:**
  - A stalled last pair blocks new input.
  - Non-last pairs in S1 never stall.
  - The pair after a stalled last waits with `in_rdy`=0.
- **Reset release:** on deassertion, `in_rdy`=1 in the first cycle.

## Test plan
- **Single pair:** a=3, b=-5 (0xFFFFFFFB), last=1, SIGNED=1, handshake in cycle k -> `out_vld`=1 in cycle k+2, `out_acc`=-15 sign-extended to 72 bits, `out_cnt`=1, `out_ovf`=0.
- **Dot product:** pairs (1,2), (3,4), (-5,6), (7,-8), last on the 4th, back-to-back -> `out_acc`=-72, `out_cnt`=4. The next group (2,2,last) gives `out_acc`=4 and `out_cnt`=1, proving clear.
- **Extremes:**
  - 255 pairs of 0x80000000*0x80000000 (2^62 each) -> `out_acc`=255*2^62, `out_cnt`=255, `out_ovf`=0.
  - Same with 300 pairs -> `out_cnt`=255 and `out_ovf`=1.
- **Backpressure:**
  - Setup: `out_rdy`=0; send group A (1*1, last) then group B (2*3, last) back-to-back.
  - While `out_rdy`=0: `out_acc`=1 holds and `in_rdy`=0 while B's last sits in S1.
  - Raise `out_rdy` -> `out_acc`=1 accepted, then `out_acc`=6 the following cycle; no loss or duplication.
- **Reset mid-group:** send (10,10), (10,10) non-last, pulse `rst` asynchronously mid-cycle -> all outputs 0 immediately. Then send (4,4,last) -> `out_acc`=16, `out_cnt`=1.
- **Unsigned build:** SIGNED=0, a=b=0xFFFFFFFF, last -> `out_acc`=0xFFFFFFFE00000001 zero-extended, `out_ovf`=0.
